// File: rtl/nfc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : nfc_pkg                                                |
// | Description : Shared types and defaults for the NAND page reader.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package nfc_pkg;

    localparam int         c_STATE_W      = 4;
    localparam logic [7:0] CMD_READ_DEF   = 8'h00;
    localparam int         PAGE_BYTES_DEF = 512;
    localparam int         PAGE_W         = 9;

    typedef logic [7:0] io_byte_t;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE    = 4'd0,
        CMD     = 4'd1,
        ADDR    = 4'd2,
        TWB     = 4'd3,
        WAIT_RB = 4'd4,
        RD_LO   = 4'd5,
        RD_HI   = 4'd6,
        HOLD    = 4'd7,
        FIN     = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nand_wr_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nand_wr_cycle                                          |
// | Description : Two-clock flash write strobe (WE# low, then high with  |
// |               the IO value held). o_last marks the second clock.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module nand_wr_cycle
    import nfc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_go,
    input  io_byte_t i_data,
    output logic     o_wen,
    output io_byte_t o_io_out,
    output logic     o_last
);

    logic     r_wen;
    io_byte_t r_io;
    logic     r_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wen  <= 1'b1;
            r_io   <= 8'h00;
            r_last <= 1'b0;
        end else begin
            r_last <= 1'b0;
            if (i_go) begin
                r_wen <= 1'b0;
                r_io  <= i_data;
            end else if (!r_wen) begin
                r_wen  <= 1'b1;
                r_last <= 1'b1;
            end
        end
    end

    assign o_wen    = r_wen;
    assign o_io_out = r_io;
    assign o_last   = r_last;

endmodule
`default_nettype wire

// File: rtl/nand_page_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nand_page_reader                                       |
// | Description : Issues READ + 3 address cycles, waits on R/B, then     |
// |               streams PAGE_BYTES bytes with a ready/valid output.    |
// |               NPR_RB_TIMEOUT_EN adds an R/B timeout that pulses err. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module nand_page_reader
    import nfc_pkg::*;
#(
    parameter int         PAGE_BYTES = PAGE_BYTES_DEF,
    parameter logic [7:0] CMD_READ   = CMD_READ_DEF,
    parameter int         TWB_CYCLES = 5,
    parameter int         TO_CYCLES  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAGE_W-1:0] page,
    output logic              busy,
    output logic              page_done,
    output logic              err,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [7:0]        f_io_out,
    output logic              f_io_oe,
    input  logic [7:0]        f_io_in,
    output logic              f_cle,
    output logic              f_ale,
    output logic              f_wen,
    output logic              f_ren,
    input  logic              f_rb
);

    localparam int c_BCNT_W = $clog2(PAGE_BYTES) + 1;
    localparam int c_TWB_W  = $clog2(TWB_CYCLES + 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(PAGE_BYTES - 1);
    localparam logic [c_TWB_W-1:0]  c_TWB_LAST  = c_TWB_W'(TWB_CYCLES - 1);

    state_t              r_state, w_state_nxt;
    logic [PAGE_W-1:0]   r_page;
    logic [1:0]          r_aidx;
    logic [c_TWB_W-1:0]  r_twb_cnt;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic                r_busy, r_page_done, r_cle, r_ale, r_oe, r_ren, r_dout_valid;
    io_byte_t            r_dout;

    logic     w_accept, w_consume, w_timeout, w_wr_last, w_wr_go;
    io_byte_t w_wr_data;
    logic     w_busy_nxt, w_done_nxt, w_cle_nxt, w_ale_nxt, w_oe_nxt, w_ren_nxt;

    assign w_accept  = ((r_state == IDLE) || (r_state == FIN)) && start;
    assign w_consume = r_dout_valid && dout_ready;

`ifdef NPR_RB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TO_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TO_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == WAIT_RB) ? r_to_cnt + 1'b1 : '0;
            r_err    <= w_timeout;
        end
    end

    // A late ready on the expiring cycle still wins over the timeout.
    assign w_timeout = (r_state == WAIT_RB) && !f_rb && (r_to_cnt == c_TO_LAST);
    assign err       = r_err;
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYCLES > 0);
    assign w_timeout   = 1'b0;
    assign err         = 1'b0;
`endif

    nand_wr_cycle u_wr (
        .clk      (clk),
        .rst      (rst),
        .i_go     (w_wr_go),
        .i_data   (w_wr_data),
        .o_wen    (f_wen),
        .o_io_out (f_io_out),
        .o_last   (w_wr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_page       <= '0;
            r_aidx       <= 2'd0;
            r_twb_cnt    <= '0;
            r_bcnt       <= '0;
            r_busy       <= 1'b0;
            r_page_done  <= 1'b0;
            r_cle        <= 1'b0;
            r_ale        <= 1'b0;
            r_oe         <= 1'b0;
            r_ren        <= 1'b1;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_page_done <= w_done_nxt;
            r_cle       <= w_cle_nxt;
            r_ale       <= w_ale_nxt;
            r_oe        <= w_oe_nxt;
            r_ren       <= w_ren_nxt;
            if (w_accept) begin
                r_page <= page;
                r_bcnt <= '0;
            end else if (w_consume) begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            r_aidx    <= (r_state == ADDR) ? (w_wr_last ? r_aidx + 2'd1 : r_aidx) : 2'd0;
            r_twb_cnt <= (r_state == TWB) ? r_twb_cnt + 1'b1 : '0;
            if (r_state == RD_HI) begin
                r_dout       <= f_io_in;
                r_dout_valid <= 1'b1;
            end else if (w_consume) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CMD;
            FIN:     w_state_nxt = start ? CMD : IDLE;
            CMD:     if (w_wr_last) w_state_nxt = ADDR;
            ADDR:    if (w_wr_last && (r_aidx == 2'd2)) w_state_nxt = TWB;
            TWB:     if (r_twb_cnt == c_TWB_LAST) w_state_nxt = WAIT_RB;
            WAIT_RB: begin
                if (f_rb)           w_state_nxt = RD_LO;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            RD_LO:   w_state_nxt = RD_HI;
            RD_HI:   w_state_nxt = HOLD;
            HOLD:    if (w_consume) w_state_nxt = (r_bcnt == c_BCNT_LAST) ? FIN : RD_LO;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_comb begin
        w_wr_go   = 1'b0;
        w_wr_data = 8'h00;
        case (r_state)
            IDLE, FIN: if (start) begin
                w_wr_go   = 1'b1;
                w_wr_data = CMD_READ;
            end
            CMD: if (w_wr_last) w_wr_go = 1'b1;
            ADDR: if (w_wr_last && (r_aidx != 2'd2)) begin
                w_wr_go   = 1'b1;
                w_wr_data = (r_aidx == 2'd0) ? r_page[7:0] : {7'b0, r_page[PAGE_W-1]};
            end
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != FIN);
        w_done_nxt = (w_state_nxt == FIN);
        w_cle_nxt  = (w_state_nxt == CMD);
        w_ale_nxt  = (w_state_nxt == ADDR);
        w_oe_nxt   = (w_state_nxt == CMD) || (w_state_nxt == ADDR);
        w_ren_nxt  = (w_state_nxt != RD_LO);
    end

    assign busy       = r_busy;
    assign page_done  = r_page_done;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign f_io_oe    = r_oe;
    assign f_cle      = r_cle;
    assign f_ale      = r_ale;
    assign f_ren      = r_ren;

endmodule
`default_nettype wire

// File: tb/tb_nand_page_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_nand_page_reader                                    |
// | Description : Self-checking bench with a flash model and scoreboard. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_nand_page_reader;

    localparam int PAGE_BYTES = 512;
    localparam int TWB_CYCLES = 5;
    localparam int TO_CYCLES  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [8:0] page = 9'h000;
    logic       dout_ready = 1'b0;
    logic [7:0] f_io_in = 8'h00;
    logic       f_rb = 1'b1;
    logic       busy, page_done, err, dout_valid, f_io_oe, f_cle, f_ale, f_wen, f_ren;
    logic [7:0] dout, f_io_out;

    nand_page_reader #(
        .PAGE_BYTES (PAGE_BYTES),
        .CMD_READ   (8'h00),
        .TWB_CYCLES (TWB_CYCLES),
        .TO_CYCLES  (TO_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .page(page),
        .busy(busy), .page_done(page_done), .err(err),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .f_io_out(f_io_out), .f_io_oe(f_io_oe), .f_io_in(f_io_in),
        .f_cle(f_cle), .f_ale(f_ale), .f_wen(f_wen), .f_ren(f_ren), .f_rb(f_rb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: byte i of the page is i[7:0], presented on each RE# fall.
    int flash_cnt  = 0;
    int flash_base = 0;
    always @(negedge f_ren) begin
        f_io_in   = 8'(flash_cnt - flash_base);
        flash_cnt = flash_cnt + 1;
    end

    logic [7:0]  got_q[$];
    logic [10:0] wr_q[$];
    int cle_cyc = 0, ale_cyc = 0, ren_dv_viol = 0, hold_bad = 0, dout_chg_bad = 0;
    int done_cnt = 0, done_cyc = 0, cons_cyc = 0, err_cnt = 0, err_cyc = 0;
    logic done_dv = 1'b0, done_busy = 1'b0, err_busy = 1'b0;
    logic prev_wen_low = 1'b0, prev_dv = 1'b0, prev_cons = 1'b0, prev_rst = 1'b0;
    logic [7:0] prev_io = 8'h00, prev_dout = 8'h00;

    always @(negedge clk) begin
        if (!f_wen) wr_q.push_back({f_cle, f_ale, f_io_oe, f_io_out});
        if (f_cle) cle_cyc++;
        if (f_ale) ale_cyc++;
        if (!f_ren && dout_valid) ren_dv_viol++;
        if (prev_wen_low && f_wen && (f_io_out !== prev_io)) hold_bad++;
        if (prev_rst && prev_dv && !prev_cons && (dout !== prev_dout)) dout_chg_bad++;
        prev_wen_low = !f_wen;
        prev_io      = f_io_out;
        prev_dv      = dout_valid;
        prev_dout    = dout;
        prev_cons    = rst && dout_valid && dout_ready;
        prev_rst     = rst;
        if (rst && dout_valid && dout_ready) begin
            got_q.push_back(dout);
            cons_cyc = cyc;
        end
        if (page_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_dv   = dout_valid;
            done_busy = busy;
        end
        if (err) begin
            err_cnt++;
            err_cyc  = cyc;
            err_busy = busy;
        end
    end

    int gbase = 0, wbase = 0, dbase = 0, cbase = 0, abase = 0;

    function automatic logic [10:0] exp_wr(input logic [8:0] p, input int k);
        case (k)
            0:       return {3'b101, 8'h00};
            1:       return {3'b011, 8'h00};
            2:       return {3'b011, p[7:0]};
            default: return {3'b011, 7'b0, p[8]};
        endcase
    endfunction

    function automatic int stream_bad(input int base);
        int bad = 0;
        if (got_q.size() - base != PAGE_BYTES) return PAGE_BYTES;
        for (int k = 0; k < PAGE_BYTES; k++)
            if (got_q[base + k] !== 8'(k)) bad++;
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_page(input logic [8:0] p, input bit release_rst);
        flash_base = flash_cnt;
        gbase = got_q.size();
        wbase = wr_q.size();
        dbase = done_cnt;
        cbase = cle_cyc;
        abase = ale_cyc;
        if (release_rst) rst = 1'b1;
        start = 1'b1;
        page  = p;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int mode, input int poke_at, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8000 && !ok; c++) begin
            dout_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (c == poke_at) begin
                start = 1'b1;
                page  = 9'($urandom_range(0, 511));
            end
            tick();
            start = 1'b0;
            if (done_cnt != dbase) ok = 1'b1;
        end
    endtask

    task automatic check_page_end(input string name, input bit ok);
        int bad;
        n_checks++;
        if (!ok) $display("FAIL %s_done_timeout: page_done not seen within budget", name);
        else n_pass++;
        bad = stream_bad(gbase);
        n_checks++;
        if (bad != 0) $display("FAIL %s_stream: %0d bad of %0d bytes (got %0d bytes)", name, bad, PAGE_BYTES, got_q.size() - gbase);
        else n_pass++;
        n_checks++;
        if (done_cyc != cons_cyc + 1) $display("FAIL %s_done_latency: page_done cycle %0d, required %0d", name, done_cyc, cons_cyc + 1);
        else n_pass++;
        n_checks++;
        if ({done_dv, done_busy} !== 2'b00) $display("FAIL %s_done_flags: dout_valid,busy=%b required 00", name, {done_dv, done_busy});
        else n_pass++;
    endtask

    logic [24:0] c_rst_vec = {3'b000, 8'h00, 1'b0, 8'h00, 3'b000, 2'b11};

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        dout_ready = 1'b0;
        f_rb = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, page_done, err, dout, dout_valid, f_io_out, f_io_oe, f_cle, f_ale, f_wen, f_ren} !== c_rst_vec)
            $display("FAIL reset_values: got %h required %h",
                     {busy, page_done, err, dout, dout_valid, f_io_out, f_io_oe, f_cle, f_ale, f_wen, f_ren}, c_rst_vec);
        else n_pass++;
        start_page(9'h1A5, 1'b1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL start_after_reset: busy=%b required 1", busy);
        else n_pass++;
    endtask

    task automatic test_cmd_addr();
        bit ok;
        int bad = 0;
        for (int c = 0; c < 40 && !(wr_q.size() - wbase == 4 && f_wen); c++) tick();
        repeat (3) tick();
        n_checks++;
        if (wr_q.size() - wbase != 4) $display("FAIL wr_count: got %0d write cycles required 4", wr_q.size() - wbase);
        else n_pass++;
        for (int k = 0; k < 4; k++)
            if (wr_q.size() > wbase + k && wr_q[wbase + k] !== exp_wr(9'h1A5, k)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL wr_sequence: %0d write cycles wrong (first %h, required %h)", bad, wr_q[wbase], exp_wr(9'h1A5, 0));
        else n_pass++;
        n_checks++;
        if ({cle_cyc - cbase, ale_cyc - abase} !== {32'd2, 32'd6})
            $display("FAIL latch_cycles: cle=%0d ale=%0d required 2 and 6", cle_cyc - cbase, ale_cyc - abase);
        else n_pass++;
        n_checks++;
        if (f_io_oe !== 1'b0) $display("FAIL oe_after_addr: f_io_oe=%b required 0", f_io_oe);
        else n_pass++;
        run_to_done(0, -1, ok);
        check_page_end("full_page", ok);
    endtask

    task automatic test_rb_wait();
        bit ok;
        int early = 0;
        logic [8:0] p = 9'($urandom_range(0, 511));
        f_rb = 1'b0;
        dout_ready = 1'b1;
        start_page(p, 1'b0);
        for (int c = 0; c < 40 && !(wr_q.size() - wbase == 4 && f_wen); c++) tick();
        for (int c = 0; c < TWB_CYCLES + 50; c++) begin
            tick();
            if (!f_ren) early++;
        end
        n_checks++;
        if (early != 0) $display("FAIL rb_wait_ren: f_ren low %0d cycles while f_rb=0, required 0", early);
        else n_pass++;
        f_rb = 1'b1;
        tick();
        n_checks++;
        if (f_ren !== 1'b0) $display("FAIL rb_release_ren: f_ren=%b the cycle after f_rb=1, required 0", f_ren);
        else n_pass++;
        run_to_done(0, -1, ok);
        check_page_end("rb_page", ok);
    endtask

    task automatic test_backpressure();
        bit ok = 1'b0;
        int bad = 0;
        start_page(9'($urandom_range(0, 511)), 1'b0);
        dout_ready = 1'b1;
        for (int c = 0; c < 1000 && !(dout_valid && got_q.size() - gbase == 37); c++) tick();
        dout_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if ({f_ren, dout_valid, dout} !== {2'b11, 8'h25}) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL stall_hold: %0d stalled cycles with ren,valid,dout=%b,%b,%h required 1,1,25", bad, f_ren, dout_valid, dout);
        else n_pass++;
        run_to_done(0, -1, ok);
        check_page_end("stall_page", ok);
    endtask

    task automatic test_reset_midpage();
        bit ok;
        start_page(9'($urandom_range(0, 511)), 1'b0);
        dout_ready = 1'b1;
        for (int c = 0; c < 1000 && (got_q.size() - gbase < 100); c++) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({busy, page_done, err, dout, dout_valid, f_io_out, f_io_oe, f_cle, f_ale, f_wen, f_ren} !== c_rst_vec)
            $display("FAIL midpage_reset: got %h required %h",
                     {busy, page_done, err, dout, dout_valid, f_io_out, f_io_oe, f_cle, f_ale, f_wen, f_ren}, c_rst_vec);
        else n_pass++;
        n_checks++;
        if (done_cnt != dbase) $display("FAIL midpage_no_done: %0d page_done pulses, required 0", done_cnt - dbase);
        else n_pass++;
        tick();
        start_page(9'h000, 1'b1);
        run_to_done(0, -1, ok);
        check_page_end("after_reset", ok);
    endtask

    task automatic test_random_pages();
        for (int it = 0; it < 2; it++) begin
            bit ok;
            int bad = 0;
            logic [8:0] p = 9'($urandom_range(0, 511));
            start_page(p, 1'b0);
            run_to_done(1, (it == 0) ? 300 : -1, ok);
            for (int k = 0; k < 4; k++)
                if (wr_q.size() > wbase + k && wr_q[wbase + k] !== exp_wr(p, k)) bad++;
            n_checks++;
            if (bad != 0 || wr_q.size() - wbase != 4)
                $display("FAIL rand_wr_seq: page %h, %0d writes, %0d wrong, required 4 and 0", p, wr_q.size() - wbase, bad);
            else n_pass++;
            check_page_end("rand_page", ok);
            tick();
        end
    endtask

`ifdef NPR_RB_TIMEOUT_EN
    task automatic test_timeout();
        int s;
        int e0 = err_cnt;
        f_rb = 1'b0;
        start_page(9'($urandom_range(0, 511)), 1'b0);
        s = cyc;
        for (int c = 0; c < 200 && err_cnt == e0; c++) tick();
        tick();
        n_checks++;
        if (err_cnt - e0 != 1) $display("FAIL timeout_err: %0d err pulses, required 1", err_cnt - e0);
        else n_pass++;
        n_checks++;
        if (err_cyc != s + 8 + TWB_CYCLES + TO_CYCLES) $display("FAIL timeout_cycle: err at %0d required %0d", err_cyc, s + 8 + TWB_CYCLES + TO_CYCLES);
        else n_pass++;
        n_checks++;
        if ({err_busy, busy, 1'(done_cnt != dbase)} !== 3'b000)
            $display("FAIL timeout_flags: busy_at_err,busy,done=%b required 000", {err_busy, busy, 1'(done_cnt != dbase)});
        else n_pass++;
        f_rb = 1'b1;
    endtask
`endif

    task automatic test_invariants();
        n_checks++;
        if (ren_dv_viol != 0) $display("FAIL ren_with_valid: %0d cycles, required 0", ren_dv_viol);
        else n_pass++;
        n_checks++;
        if (hold_bad != 0) $display("FAIL wr_data_hold: %0d cycles, required 0", hold_bad);
        else n_pass++;
        n_checks++;
        if (dout_chg_bad != 0) $display("FAIL dout_stable: %0d changes while unconsumed, required 0", dout_chg_bad);
        else n_pass++;
        n_checks++;
        if (err_cnt != 0 && !`ifdef NPR_RB_TIMEOUT_EN 1'b1 `else 1'b0 `endif)
            $display("FAIL err_pulses: %0d unexpected err pulses, required 0", err_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cmd_addr();
        test_rb_wait();
        test_backpressure();
        test_reset_midpage();
        test_random_pages();
`ifdef NPR_RB_TIMEOUT_EN
        test_timeout();
`endif
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
